// File: rtl/mult_pkg.sv
// Shared constants, state encoding and sizing helper for the
// sequential shift-add multiplier (mult_24bit and mult_step).
package mult_pkg;

  localparam int WIDTH_DEF = 24;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add iteration of the multiplier.
// Ports:
//   i_acc   - {partial product high, remaining multiplier bits}
//   i_lsb   - current multiplier bit
//   i_mcand - multiplicand
//   o_acc   - accumulator after add and right shift
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic               i_lsb,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_addend;
  logic             w_unused_bit;

  assign w_addend = i_mcand & {WIDTH{i_lsb}};

  // Carry out of the add becomes the new MSB after the shift.
  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + {1'b0, w_addend};

  assign o_acc = {w_sum, i_acc[WIDTH-1:1]};

  // The consumed multiplier bit arrives separately on i_lsb.
  assign w_unused_bit = i_acc[0];

endmodule

// File: rtl/mult_24bit.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-add multiplier,
// fixed latency: Done follows the (WIDTH+1)th edge after accept.
// Ports:
//   i_clk, i_rst (sync, active high)
//   i_start, i_op_a, i_op_b, i_signed - request and operands
//   o_busy, o_done - status; o_result_lo/hi - product halves
// Option: define MULT_SIGNED_EN for two's-complement mode
// selected by i_signed; otherwise i_signed is ignored.
module mult_24bit
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_signed,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_step;
  logic w_finish;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_lsb   (r_acc[0]),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // RUN steps while the counter is below WIDTH; the visit
  // with counter == WIDTH publishes the product.
  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) begin
          w_next   = ST_DONE;
          w_finish = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef MULT_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg;

  assign w_neg_a = i_signed & i_op_a[WIDTH-1];
  assign w_neg_b = i_signed & i_op_b[WIDTH-1];

  // Magnitude of the most negative value still fits unsigned.
  assign w_mag_a = w_neg_a ? -i_op_a : i_op_a;
  assign w_mag_b = w_neg_b ? -i_op_b : i_op_b;

  assign w_prod = r_neg ? -r_acc : r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg_a ^ w_neg_b;
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_mag_a = i_op_a;
  assign w_mag_b = i_op_b;
  assign w_prod  = r_acc;
`endif

  // Low half of r_acc doubles as the multiplier register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_mcand <= w_mag_a;
        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_nxt;
      end
      if (w_finish) begin
        r_res_lo <= w_prod[WIDTH-1:0];
        r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_result_lo = r_res_lo;
  assign o_result_hi = r_res_hi;

endmodule

// File: tb/tb_mult_24bit.sv
// Self-checking bench for mult_24bit: vector table, corner
// sequences and random operations against an arithmetic model.
module tb_mult_24bit;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_lo = '0;
  logic [W-1:0] prev_hi = '0;

  always #5 clk = ~clk;

  mult_24bit #(
    .WIDTH (W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op_a      (a),
    .i_op_b      (b),
    .i_signed    (sgn),
    .o_busy      (busy),
    .o_done      (done),
    .o_result_lo (lo),
    .o_result_hi (hi)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         s);
    logic [47:0]        p;
    logic signed [47:0] sx;
    logic signed [47:0] sy;
    p  = 48'(x) * 48'(y);
    sx = $signed(x);
    sy = $signed(y);
`ifdef MULT_SIGNED_EN
    if (s) p = sx * sy;
`else
    if (s) p = 48'(x) * 48'(y);
`endif
    return p;
  endfunction

  task automatic do_op(input logic [W-1:0] ia,
                       input logic [W-1:0] ib,
                       input logic         is,
                       input logic [W-1:0] elo,
                       input logic [W-1:0] ehi,
                       input string        tag);
    int n;
    @(negedge clk);
    a = ia; b = ib; sgn = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    a = W'($urandom);
    b = W'($urandom);
    sgn = ~is;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 12) begin
        chk({tag, " hold"}, {hi, lo}, {prev_hi, prev_lo});
      end
    end
    chk({tag, " latency"}, n, 25);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " hi"}, hi, ehi);
    prev_lo = elo;
    prev_hi = ehi;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [W-1:0] rlo;
    logic [W-1:0] rhi;
    logic [47:0]  e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    tbl[0] = '{24'h000003, 24'h000005, 1'b0,
               24'h00000F, 24'h000000};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0,
               24'h000001, 24'hFFFFFE};
    tbl[2] = '{24'h000000, 24'h000000, 1'b0,
               24'h000000, 24'h000000};
    tbl[3] = '{24'h000000, 24'hABCDEF, 1'b0,
               24'h000000, 24'h000000};
`ifdef MULT_SIGNED_EN
    tbl[4] = '{24'hFFFFFE, 24'h000003, 1'b1,
               24'hFFFFFA, 24'hFFFFFF};
`else
    tbl[4] = '{24'hFFFFFE, 24'h000003, 1'b1,
               24'hFFFFFA, 24'h000002};
`endif
    tbl[5] = '{24'h800000, 24'h800000, 1'b1,
               24'h000000, 24'h400000};
    tbl[6] = '{24'h7FFFFF, 24'h000002, 1'b1,
               24'hFFFFFE, 24'h000000};
    tbl[7] = '{24'h123456, 24'h000001, 1'b0,
               24'h123456, 24'h000000};

    rst = 1'b1; start = 1'b0; sgn = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("in reset", {busy, done, hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle after reset", {busy, done, hi, lo}, '0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s,
            tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));
    end

    // Start and operand change mid-RUN are ignored.
    @(negedge clk);
    a = 24'd7; b = 24'd9; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; a = 24'hFFFFFF;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0; rlo = '0; rhi = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        rlo = lo; rhi = hi;
      end
    end
    chk("midrun pulses", pulses, 1);
    chk("midrun result", {rhi, rlo}, {24'd0, 24'd63});
    chk("midrun idle", busy, 0);

    // Reset at RUN cycle 10 aborts and clears outputs.
    @(negedge clk);
    a = 24'd11; b = 24'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort cleared", {busy, done, hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort no done", pulses, 0);
    prev_lo = '0; prev_hi = '0;

    // Reset wins over a simultaneous Start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 24'd5; b = 24'd5;
    @(posedge clk); #1;
    chk("rst prio busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst prio idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i < 3) ra[W-1] = 1'b1;
      e = ref_mul(ra, rb, rs);
      do_op(ra, rb, rs, e[W-1:0], e[2*W-1:W],
            $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
